// File: rtl/door_timer_ctrl.sv
// ---------------------------------------------------------------------------
// door_timer_ctrl
//
// Purpose:
//   Elevator door sequencer paced by the one-cycle `tick` strobe from the
//   prescaler/delay counter. The door steps through CLOSED -> OPENING -> OPEN
//   -> CLOSING -> CLOSED. Each timed phase lasts a fixed number of ticks.
//   An obstruction or an open request holds the dwell while the door is open.
//   The same events make a closing door reopen fully. A sticky interlock
//   error flags any cycle where the car moves while the door is not closed.
//
// Ports:
//   clk           - system clock, rising edge
//   rst           - synchronous active-high reset, highest priority
//   tick          - one-cycle time-base strobe
//   open_req      - open / hold-open request (level)
//   close_req     - door-close button (level)
//   obstruction   - light curtain blocked
//   car_moving    - car is not stationary
//   door_closed   - door fully closed (CLOSED)
//   door_open     - door fully open (OPEN)
//   motor_open    - drive motor in the open direction (OPENING)
//   motor_close   - drive motor in the close direction (CLOSING)
//   closed_pulse  - one-cycle pulse on CLOSING -> CLOSED
//   interlock_err - sticky, car moved while door not closed; cleared by rst
// ---------------------------------------------------------------------------
module door_timer_ctrl #(
  parameter int OPEN_TICKS  = 2,
  parameter int DWELL_TICKS = 4,
  parameter int CLOSE_TICKS = 2,
  parameter int CNT_W       = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic open_req,
  input  logic close_req,
  input  logic obstruction,
  input  logic car_moving,
  output logic door_closed,
  output logic door_open,
  output logic motor_open,
  output logic motor_close,
  output logic closed_pulse,
  output logic interlock_err
);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPENING = 2'd1,
    ST_OPEN    = 2'd2,
    ST_CLOSING = 2'd3
  } state_e;

  // Terminal counts. The tick that lands on one of these values takes the
  // transition on that same edge. As a result, a phase lasts exactly *_TICKS
  // ticks after entry.
  localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_TICKS - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(CLOSE_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             door_closed_q, door_closed_d;
  logic             door_open_q, door_open_d;
  logic             motor_open_q, motor_open_d;
  logic             motor_close_q, motor_close_d;
  logic             closed_pulse_q, closed_pulse_d;
  logic             interlock_err_q, interlock_err_d;

  // Next-state and counter logic. Within a state, events are evaluated
  // before the tick. An event on the same cycle as a tick therefore
  // discards that tick.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    closed_pulse_d = 1'b0;

    case (state_q)
      ST_CLOSED: begin
        // Opening is refused while the car is still moving.
        if (open_req && !car_moving) begin
          state_d = ST_OPENING;
          cnt_d   = '0;
        end
      end

      ST_OPENING: begin
        // The door always finishes opening. Requests and obstruction do not
        // hold back the tick count.
        if (tick) begin
          if (cnt_q == OPEN_LAST) begin
            state_d = ST_OPEN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_OPEN: begin
        if (obstruction || open_req) begin
          cnt_d = '0;
        end else if (close_req) begin
          state_d = ST_CLOSING;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ST_CLOSING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_CLOSING: begin
        if (obstruction || open_req) begin
          state_d = ST_OPENING;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CLOSE_LAST) begin
            state_d        = ST_CLOSED;
            cnt_d          = '0;
            closed_pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_CLOSED;
        cnt_d   = '0;
      end
    endcase

    // Status flops load the decode of the next state. They therefore always
    // match the state register after each edge.
    door_closed_d = (state_d == ST_CLOSED);
    door_open_d   = (state_d == ST_OPEN);
    motor_open_d  = (state_d == ST_OPENING);
    motor_close_d = (state_d == ST_CLOSING);

    // Monitoring only. The error is sticky until reset and never feeds back
    // into sequencing.
    interlock_err_d = interlock_err_q | (car_moving && (state_q != ST_CLOSED));
  end

  // State, counter and registered outputs. Reset lands in CLOSED without
  // raising closed_pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_CLOSED;
      cnt_q           <= '0;
      door_closed_q   <= 1'b1;
      door_open_q     <= 1'b0;
      motor_open_q    <= 1'b0;
      motor_close_q   <= 1'b0;
      closed_pulse_q  <= 1'b0;
      interlock_err_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      door_closed_q   <= door_closed_d;
      door_open_q     <= door_open_d;
      motor_open_q    <= motor_open_d;
      motor_close_q   <= motor_close_d;
      closed_pulse_q  <= closed_pulse_d;
      interlock_err_q <= interlock_err_d;
    end
  end

  assign door_closed   = door_closed_q;
  assign door_open     = door_open_q;
  assign motor_open    = motor_open_q;
  assign motor_close   = motor_close_q;
  assign closed_pulse  = closed_pulse_q;
  assign interlock_err = interlock_err_q;

endmodule

// File: tb/tb_door_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_door_timer_ctrl
//
// Directed bench for door_timer_ctrl with its default parameters:
// OPEN_TICKS=2, DWELL_TICKS=4, CLOSE_TICKS=2.
// Each step drives one cycle of inputs. It then compares the packed status
// word {door_closed, door_open, motor_open, motor_close, closed_pulse,
// interlock_err} against a hand-computed value.
// ---------------------------------------------------------------------------
module tb_door_timer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic open_req = 1'b0;
  logic close_req = 1'b0;
  logic obstruction = 1'b0;
  logic car_moving = 1'b0;
  logic door_closed, door_open, motor_open, motor_close, closed_pulse, interlock_err;

  int errCount   = 0;
  int checkCount = 0;

  localparam logic [5:0] S_CLOSED  = 6'b100000;
  localparam logic [5:0] S_OPEN    = 6'b010000;
  localparam logic [5:0] S_OPENING = 6'b001000;
  localparam logic [5:0] S_CLOSING = 6'b000100;
  localparam logic [5:0] PULSE     = 6'b000010;
  localparam logic [5:0] ILK       = 6'b000001;

  door_timer_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .open_req     (open_req),
    .close_req    (close_req),
    .obstruction  (obstruction),
    .car_moving   (car_moving),
    .door_closed  (door_closed),
    .door_open    (door_open),
    .motor_open   (motor_open),
    .motor_close  (motor_close),
    .closed_pulse (closed_pulse),
    .interlock_err(interlock_err)
  );

  always #5 clk = ~clk;

  wire [5:0] status = {door_closed, door_open, motor_open, motor_close, closed_pulse, interlock_err};

  // Drive one cycle of inputs. Afterwards, settle 1 time unit past the
  // rising edge so that outputs are sampled away from the edge.
  task automatic applyStimulus(input logic r, input logic t, input logic o,
                               input logic c, input logic ob, input logic m);
    rst         = r;
    tick        = t;
    open_req    = o;
    close_req   = c;
    obstruction = ob;
    car_moving  = m;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: status got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Inputs in order: rst, tick, open_req, close_req, obstruction, car_moving.
  task automatic step(input string tag, input logic r, input logic t, input logic o,
                      input logic c, input logic ob, input logic m, input logic [5:0] exp);
    applyStimulus(r, t, o, c, ob, m);
    checkOutput(tag, status, exp);
  endtask

  initial begin
    // Reset
    #1;
    step("reset0", 1, 0, 0, 0, 0, 0, S_CLOSED);
    step("reset1", 1, 1, 1, 0, 0, 0, S_CLOSED);
    step("idle_tick_closed", 0, 1, 0, 1, 1, 0, S_CLOSED);

    // Full cycle: open, dwell, close
    step("open_req", 0, 0, 1, 0, 0, 0, S_OPENING);
    step("opening_t1", 0, 1, 0, 0, 0, 0, S_OPENING);
    step("opening_notick", 0, 0, 0, 0, 0, 0, S_OPENING);
    step("opening_t2", 0, 1, 0, 0, 0, 0, S_OPEN);
    step("dwell_t1", 0, 1, 0, 0, 0, 0, S_OPEN);
    step("dwell_t2", 0, 1, 0, 0, 0, 0, S_OPEN);
    step("dwell_t3", 0, 1, 0, 0, 0, 0, S_OPEN);
    step("dwell_t4", 0, 1, 0, 0, 0, 0, S_CLOSING);
    step("closing_t1", 0, 1, 0, 0, 0, 0, S_CLOSING);
    step("closing_t2", 0, 1, 0, 0, 0, 0, S_CLOSED | PULSE);
    step("pulse_once", 0, 0, 0, 0, 0, 0, S_CLOSED);

    // Obstruction holds the dwell
    step("reopen", 0, 0, 1, 0, 0, 0, S_OPENING);
    step("reopen_t1", 0, 1, 0, 0, 0, 0, S_OPENING);
    step("reopen_t2", 0, 1, 0, 0, 0, 0, S_OPEN);
    for (int i = 0; i < 3; i++) step("dwell_to_cnt3", 0, 1, 0, 0, 0, 0, S_OPEN);
    for (int i = 0; i < 10; i++) step("obstruct_hold", 0, 1, 0, 0, 1, 0, S_OPEN);
    for (int i = 0; i < 3; i++) step("after_obstruct", 0, 1, 0, 0, 0, 0, S_OPEN);
    step("after_obstruct_t4", 0, 1, 0, 0, 0, 0, S_CLOSING);

    // Obstruction while closing forces a full reopen
    step("closing_cnt1", 0, 1, 0, 0, 0, 0, S_CLOSING);
    step("closing_obstruct", 0, 0, 0, 0, 1, 0, S_OPENING);
    step("reopened_t1", 0, 1, 0, 0, 0, 0, S_OPENING);
    step("reopened_t2", 0, 1, 0, 0, 0, 0, S_OPEN);

    // Events beat ticks in OPEN
    for (int i = 0; i < 3; i++) step("open_cnt3", 0, 1, 0, 0, 0, 0, S_OPEN);
    step("open_req_tick", 0, 1, 1, 0, 0, 0, S_OPEN);
    for (int i = 0; i < 3; i++) step("dwell_restarted", 0, 1, 0, 0, 0, 0, S_OPEN);
    step("close_req_tick", 0, 1, 0, 1, 0, 0, S_CLOSING);

    // close_req is ignored in CLOSING; an open request with a tick reopens
    step("closing_closereq", 0, 1, 0, 1, 0, 0, S_CLOSING);
    step("closing_openreq_tick", 0, 1, 1, 0, 0, 0, S_OPENING);
    step("reopen2_t1", 0, 1, 0, 0, 0, 0, S_OPENING);
    step("reopen2_t2", 0, 1, 0, 0, 0, 0, S_OPEN);
    step("close_btn", 0, 0, 0, 1, 0, 0, S_CLOSING);
    step("close_btn_t1", 0, 1, 0, 0, 0, 0, S_CLOSING);
    step("close_btn_t2", 0, 1, 0, 0, 0, 0, S_CLOSED | PULSE);

    // Interlock behaviour
    step("moving_open_req", 0, 0, 1, 0, 0, 1, S_CLOSED);
    step("moving_closed", 0, 1, 0, 0, 0, 1, S_CLOSED);
    step("open_again", 0, 0, 1, 0, 0, 0, S_OPENING);
    step("open_again_t1", 0, 1, 0, 0, 0, 0, S_OPENING);
    step("open_again_t2", 0, 1, 0, 0, 0, 0, S_OPEN);
    step("moving_in_open", 0, 0, 0, 0, 0, 1, S_OPEN | ILK);
    step("ilk_sticky", 0, 0, 0, 1, 0, 0, S_CLOSING | ILK);
    step("ilk_close_t1", 0, 1, 0, 0, 0, 0, S_CLOSING | ILK);
    step("ilk_close_t2", 0, 1, 0, 0, 0, 0, S_CLOSED | PULSE | ILK);
    step("ilk_held", 0, 0, 0, 0, 0, 0, S_CLOSED | ILK);

    // Reset mid-CLOSING with cnt=1 and a tick in the same cycle
    step("rst_clear_ilk", 1, 0, 0, 0, 0, 0, S_CLOSED);
    step("pre_open", 0, 0, 1, 0, 0, 0, S_OPENING);
    step("pre_open_t1", 0, 1, 0, 0, 0, 0, S_OPENING);
    step("pre_open_t2", 0, 1, 0, 0, 0, 0, S_OPEN);
    step("pre_close", 0, 0, 0, 1, 0, 0, S_CLOSING);
    step("pre_close_t1_moving", 0, 1, 0, 0, 0, 1, S_CLOSING | ILK);
    step("rst_mid_closing", 1, 1, 0, 0, 0, 0, S_CLOSED);
    step("post_rst_idle", 0, 0, 0, 0, 0, 0, S_CLOSED);
    step("post_rst_open", 0, 0, 1, 0, 0, 0, S_OPENING);
    step("post_rst_t1", 0, 1, 0, 0, 0, 0, S_OPENING);
    step("post_rst_t2", 0, 1, 0, 0, 0, 0, S_OPEN);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
